// File: rtl/system_queue_request_tracker.sv
// Request tracker: tags accepted memory requests with a slot and ID, owns the global cycle counter,
// and emits one registered stat record per response. Optional macro TRACKER_OCCUPANCY_EN adds occupancy outputs.
module system_queue_request_tracker #(
  parameter int unsigned NUM_SLOTS = 16,
  parameter int unsigned SLOT_W    = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ID_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_rd_en,
  input  logic              req_wr_en,
  output logic [SLOT_W-1:0] req_slot,
  input  logic              resp_valid,
  input  logic [SLOT_W-1:0] resp_slot,
  output logic [63:0]       globalCycle,
  output logic              resp_fire,
  output logic [ID_W-1:0]   request_id,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_en,
  output logic              wr_en,
  output logic [63:0]       stat_cycle,
  output logic [63:0]       stat_latency,
  output logic              err_bad_resp
`ifdef TRACKER_OCCUPANCY_EN
  ,
  output logic [SLOT_W:0]   occupancy,
  output logic [SLOT_W:0]   occupancy_max
`endif
);

  localparam int unsigned CYC_W = 64;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;
    logic [CYC_W-1:0]  issue;
  } slot_entry_t;

  slot_entry_t              slots_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]     busy_q, busy_d;
  logic [CYC_W-1:0]         cycle_q;
  logic [ID_W-1:0]          id_q;
  logic [SLOT_W-1:0]        free_idx;
  logic                     any_free;
  logic                     accept;
  logic                     resp_hit;
  logic                     resp_bad;

  logic                     fire_q;
  logic [ID_W-1:0]          rec_id_q;
  logic [ADDR_W-1:0]        rec_addr_q;
  logic                     rec_rd_q;
  logic                     rec_wr_q;
  logic [CYC_W-1:0]         rec_cycle_q;
  logic [CYC_W-1:0]         rec_lat_q;
  logic                     err_q;

  // Lowest free slot, taken from the current bitmap so a slot freed this cycle is not reused until next
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx = SLOT_W'(i);
        any_free = 1'b1;
      end
    end
  end

  assign accept   = req_valid && any_free;
  assign resp_hit = resp_valid && busy_q[resp_slot];
  assign resp_bad = resp_valid && !busy_q[resp_slot];

  always_comb begin
    busy_d = busy_q;
    if (accept)   busy_d[free_idx]  = 1'b1;
    if (resp_hit) busy_d[resp_slot] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q      <= '0;
      cycle_q     <= '0;
      id_q        <= '0;
      fire_q      <= 1'b0;
      rec_id_q    <= '0;
      rec_addr_q  <= '0;
      rec_rd_q    <= 1'b0;
      rec_wr_q    <= 1'b0;
      rec_cycle_q <= '0;
      rec_lat_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      cycle_q <= cycle_q + CYC_W'(1);
      fire_q  <= resp_hit;
      if (accept) id_q <= id_q + ID_W'(1);
      if (resp_hit) begin
        rec_id_q    <= slots_q[resp_slot].id;
        rec_addr_q  <= slots_q[resp_slot].addr;
        rec_rd_q    <= slots_q[resp_slot].rd;
        rec_wr_q    <= slots_q[resp_slot].wr;
        rec_cycle_q <= cycle_q;
        rec_lat_q   <= cycle_q - slots_q[resp_slot].issue;
      end
      if (resp_bad) err_q <= 1'b1;
    end
  end

  // Payload storage needs no reset: contents are only read while the busy bit is set
  always_ff @(posedge clk) begin
    if (accept) begin
      slots_q[free_idx] <= '{id: id_q, addr: req_addr, rd: req_rd_en, wr: req_wr_en, issue: cycle_q};
    end
  end

  assign req_ready    = any_free;
  assign req_slot     = free_idx;
  assign globalCycle  = cycle_q;
  assign resp_fire    = fire_q;
  assign request_id   = rec_id_q;
  assign addr         = rec_addr_q;
  assign rd_en        = rec_rd_q;
  assign wr_en        = rec_wr_q;
  assign stat_cycle   = rec_cycle_q;
  assign stat_latency = rec_lat_q;
  assign err_bad_resp = err_q;

`ifdef TRACKER_OCCUPANCY_EN
  localparam int unsigned OCC_W = SLOT_W + 1;

  logic [OCC_W-1:0] occ_q, occ_d, occ_max_q;

  // Accept and release in the same cycle cancel out
  always_comb begin
    occ_d = occ_q + OCC_W'(accept) - OCC_W'(resp_hit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q     <= '0;
      occ_max_q <= '0;
    end else begin
      occ_q <= occ_d;
      if (occ_d > occ_max_q) occ_max_q <= occ_d;
    end
  end

  assign occupancy     = occ_q;
  assign occupancy_max = occ_max_q;
`endif

endmodule

// File: tb/tb_system_queue_request_tracker.sv
// Self-checking bench for system_queue_request_tracker: directed scenarios plus random traffic
// against a slot-table reference model kept in the bench.
module tb_system_queue_request_tracker;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_rd_en;
  logic        req_wr_en;
  logic [3:0]  req_slot;
  logic        resp_valid;
  logic [3:0]  resp_slot;
  logic [63:0] globalCycle;
  logic        resp_fire;
  logic [31:0] request_id;
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [63:0] stat_cycle;
  logic [63:0] stat_latency;
  logic        err_bad_resp;
`ifdef TRACKER_OCCUPANCY_EN
  logic [4:0]  occupancy;
  logic [4:0]  occupancy_max;
`endif

  system_queue_request_tracker dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rd_en(req_rd_en), .req_wr_en(req_wr_en), .req_slot(req_slot),
    .resp_valid(resp_valid), .resp_slot(resp_slot),
    .globalCycle(globalCycle), .resp_fire(resp_fire), .request_id(request_id),
    .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .stat_cycle(stat_cycle), .stat_latency(stat_latency), .err_bad_resp(err_bad_resp)
`ifdef TRACKER_OCCUPANCY_EN
    , .occupancy(occupancy), .occupancy_max(occupancy_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: table of outstanding requests indexed by slot
  bit              m_busy [16];
  int unsigned     m_id   [16];
  logic [31:0]     m_addr [16];
  bit              m_rd   [16];
  bit              m_wr   [16];
  longint unsigned m_iss  [16];
  longint unsigned m_cyc;
  int unsigned     m_next_id;
  bit              m_err;
  int              m_occ_max;

  bit              e_fire;
  int unsigned     e_id;
  logic [31:0]     e_addr;
  bit              e_rd, e_wr;
  longint unsigned e_cyc, e_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
    m_cyc = 0; m_next_id = 0; m_err = 1'b0; m_occ_max = 0;
    e_fire = 1'b0; e_id = 0; e_addr = '0; e_rd = 1'b0; e_wr = 1'b0; e_cyc = 0; e_lat = 0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
  task automatic do_reset();
    #3;
    reset = 1'b1; req_valid = 1'b0; resp_valid = 1'b0;
    #1;
    model_reset();
    chk("rst_globalCycle", globalCycle, 64'd0);
    chk("rst_resp_fire", 64'(resp_fire), 64'd0);
    chk("rst_request_id", 64'(request_id), 64'd0);
    chk("rst_stat_latency", stat_latency, 64'd0);
    chk("rst_err", 64'(err_bad_resp), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
`ifdef TRACKER_OCCUPANCY_EN
    chk("rst_occ_max", 64'(occupancy_max), 64'd0);
`endif
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, check allocation view, advance model, check registered record
  task automatic cycle(input bit v, input logic [31:0] a, input bit rd, input bit wr,
                       input bit rv, input logic [3:0] rs);
    int lo;
    bit hit;
    req_valid = v; req_addr = a; req_rd_en = rd; req_wr_en = wr;
    resp_valid = rv; resp_slot = rs;
    lo = -1;
    for (int i = 15; i >= 0; i--) if (!m_busy[i]) lo = i;
    #1;
    chk("req_ready", 64'(req_ready), 64'(lo >= 0));
    if (lo >= 0) chk("req_slot", 64'(req_slot), 64'(lo));
    hit = rv && m_busy[rs];
    if (rv && !hit) m_err = 1'b1;
    e_fire = hit;
    if (hit) begin
      e_id = m_id[rs]; e_addr = m_addr[rs]; e_rd = m_rd[rs]; e_wr = m_wr[rs];
      e_cyc = m_cyc; e_lat = m_cyc - m_iss[rs];
    end
    if (v && lo >= 0) begin
      m_id[lo] = m_next_id; m_addr[lo] = a; m_rd[lo] = rd; m_wr[lo] = wr;
      m_iss[lo] = m_cyc; m_busy[lo] = 1'b1; m_next_id++;
    end
    if (hit) m_busy[rs] = 1'b0;
    m_cyc++;
    if (busy_count() > m_occ_max) m_occ_max = busy_count();
    @(posedge clk); #1;
    chk("resp_fire", 64'(resp_fire), 64'(e_fire));
    chk("request_id", 64'(request_id), 64'(e_id));
    chk("addr", 64'(addr), 64'(e_addr));
    chk("rd_en", 64'(rd_en), 64'(e_rd));
    chk("wr_en", 64'(wr_en), 64'(e_wr));
    chk("stat_cycle", stat_cycle, e_cyc);
    chk("stat_latency", stat_latency, e_lat);
    chk("globalCycle", globalCycle, m_cyc);
    chk("err_bad_resp", 64'(err_bad_resp), 64'(m_err));
`ifdef TRACKER_OCCUPANCY_EN
    chk("occupancy", 64'(occupancy), 64'(busy_count()));
    chk("occupancy_max", 64'(occupancy_max), 64'(m_occ_max));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_rd_en = 1'b0; req_wr_en = 1'b0;
    resp_valid = 1'b0; resp_slot = '0;
    model_reset();

    // Idle after reset
    do_reset();
    idle(10);
    chk("idle_globalCycle", globalCycle, 64'd10);
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    // Single read: issue at cycle 5, respond at cycle 12
    do_reset();
    idle(5);
    cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 4'd0);
    idle(6);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0);
    chk("single_fire", 64'(resp_fire), 64'd1);
    chk("single_id", 64'(request_id), 64'd0);
    chk("single_addr", 64'(addr), 64'd256);
    chk("single_rd", 64'(rd_en), 64'd1);
    chk("single_wr", 64'(wr_en), 64'd0);
    chk("single_cycle", stat_cycle, 64'd12);
    chk("single_latency", stat_latency, 64'd7);
    idle(1);
    chk("single_pulse", 64'(resp_fire), 64'd0);

    // Fill the table, then same-cycle response and request
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b1, 1'b0, 4'd0);
    chk("full_ready", 64'(req_ready), 64'd0);
    cycle(1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b1, 4'd3);
    chk("freed_ready", 64'(req_ready), 64'd1);
    chk("freed_slot", 64'(req_slot), 64'd3);
    cycle(1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b0, 4'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd3);
    chk("refill_id", 64'(request_id), 64'd16);
    chk("refill_addr", 64'(addr), 64'hBEEF);

    // Out-of-order completion
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0, 1'b0, 4'd0);
    idle(2);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd2);
    chk("ooo_id_a", 64'(request_id), 64'd2);
    chk("ooo_lat_a", stat_latency, 64'd3);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0);
    chk("ooo_id_b", 64'(request_id), 64'd0);
    chk("ooo_lat_b", stat_latency, 64'd6);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd1);
    chk("ooo_id_c", 64'(request_id), 64'd1);
    chk("ooo_lat_c", stat_latency, 64'd6);

    // Response to a free slot is sticky until reset
    do_reset();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd5);
    chk("bad_fire", 64'(resp_fire), 64'd0);
    chk("bad_err", 64'(err_bad_resp), 64'd1);
    idle(3);
    chk("bad_sticky", 64'(err_bad_resp), 64'd1);

    // Minimum latency and reset with requests outstanding
    do_reset();
    cycle(1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 4'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0);
    chk("min_latency", stat_latency, 64'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h400 + 32'(i), 1'b0, 1'b1, 1'b0, 4'd0);
`ifdef TRACKER_OCCUPANCY_EN
    chk("midflight_occ_max", 64'(occupancy_max), 64'd4);
`endif
    do_reset();
    idle(3);
    cycle(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 4'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0);
    chk("after_rst_id", 64'(request_id), 64'd0);
    chk("after_rst_err", 64'(err_bad_resp), 64'd0);

    // Random traffic, responses usually aimed at busy slots
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [3:0] rs;
      bit         rv;
      rs = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4 && !m_busy[rs]; k++) rs = 4'($urandom_range(0, 15));
      rv = ($urandom_range(0, 99) < 45);
      cycle(bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), rv, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
